// File: rtl/uart_pkg.sv
// uart_pkg: shared divisor widths, divisor type and baud-rate helpers for the UART block
package uart_pkg;
  localparam int UART_DIV_W = 16;
  localparam int UART_FRAC_W = 4;
  typedef struct packed {
    logic [UART_DIV_W-1:0] div_int;
    logic [UART_FRAC_W-1:0] div_frac;
  } baud_div_t;
  localparam int BAUD_4800 = 4800;
  localparam int BAUD_9600 = 9600;
  localparam int BAUD_19200 = 19200;
  localparam int BAUD_38400 = 38400;
  localparam int BAUD_57600 = 57600;
  localparam int BAUD_115200 = 115200;
  localparam int BAUD_230400 = 230400;
  localparam int BAUD_460800 = 460800;
  localparam int BAUD_921600 = 921600;
  function automatic baud_div_t calc_baud_div(input longint clk_hz, input longint baud, input longint oversample);
    longint d;
    d = (clk_hz * (longint'(1) << UART_FRAC_W) + baud * oversample / 2) / (baud * oversample);
    return '{div_int: UART_DIV_W'(d >> UART_FRAC_W), div_frac: UART_FRAC_W'(d)};
  endfunction
  localparam baud_div_t DEF_BAUD_DIV = calc_baud_div(50_000_000, BAUD_115200, 16);
endpackage

// File: rtl/uart_frac_div.sv
// uart_frac_div: fractional cycle divider emitting one-cycle oversample ticks
module uart_frac_div import uart_pkg::*; #(
  parameter int DIV_W = UART_DIV_W,
  parameter int FRAC_W = UART_FRAC_W,
  parameter int DEF_DIV_INT = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic hold,
  input  logic start,
  input  logic [DIV_W-1:0] div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic tick_next,
  output logic tick
);
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [FRAC_W:0] sum;
  logic tick_q;
  always_comb begin
    sum = {1'b0, acc_q} + {1'b0, div_frac};
    tick_next = !hold && !start && cnt_q == '0;
    acc_d = hold || start ? '0 : tick_next ? sum[FRAC_W-1:0] : acc_q;
    cnt_d = hold ? div_int
          : start ? div_int - DIV_W'(1)
          : tick_next ? div_int - DIV_W'(1) + DIV_W'(sum[FRAC_W])
          : cnt_q - DIV_W'(1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= DIV_W'(DEF_DIV_INT);
      acc_q <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      tick_q <= tick_next;
    end
  end
  assign tick = tick_q;
endmodule

// File: rtl/uart_baud_tick_gen.sv
// uart_baud_tick_gen: runtime-programmable fractional baud generator emitting rx/tx tick enables
module uart_baud_tick_gen import uart_pkg::*; #(
  parameter int DIV_W = UART_DIV_W,
  parameter int FRAC_W = UART_FRAC_W,
  parameter int OVERSAMPLE = 16,
  parameter int DEF_DIV_INT = int'(DEF_BAUD_DIV.div_int),
  parameter int DEF_DIV_FRAC = int'(DEF_BAUD_DIV.div_frac)
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic rx_resync,
  input  logic cfg_valid,
  output logic cfg_ready,
  input  logic [DIV_W-1:0] cfg_div_int,
  input  logic [FRAC_W-1:0] cfg_div_frac,
  output logic cfg_err,
  output logic rx_tick,
  output logic tx_tick,
  output logic [DIV_W+FRAC_W-1:0] active_div
);
  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam logic [DIV_W+FRAC_W-1:0] DEF_DIV = {DIV_W'(DEF_DIV_INT), FRAC_W'(DEF_DIV_FRAC)};
  logic [DIV_W+FRAC_W-1:0] active_q, active_d, shadow_q, shadow_d;
  logic [OS_W-1:0] os_q, os_d;
  logic pend_q, pend_d, err_q, err_d, tx_q, tx_d;
  logic offer, apply, start, rx_next;
  always_comb begin
    offer = cfg_valid && !pend_q;
    err_d = offer && cfg_div_int < DIV_W'(2);
    apply = pend_q && (!enable || rx_resync || tx_q);
    start = enable && (rx_resync || apply);
    pend_d = (offer && !err_d) || (pend_q && !apply);
    shadow_d = offer && !err_d ? {cfg_div_int, cfg_div_frac} : shadow_q;
    active_d = apply ? shadow_q : active_q;
    tx_d = rx_next && os_q == OS_W'(OVERSAMPLE - 1);
    os_d = !enable || rx_resync || tx_d ? '0 : rx_next ? os_q + OS_W'(1) : os_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= DEF_DIV;
      shadow_q <= '0;
      pend_q <= 1'b0;
      err_q <= 1'b0;
      tx_q <= 1'b0;
      os_q <= '0;
    end else begin
      active_q <= active_d;
      shadow_q <= shadow_d;
      pend_q <= pend_d;
      err_q <= err_d;
      tx_q <= tx_d;
      os_q <= os_d;
    end
  end
  uart_frac_div #(
    .DIV_W(DIV_W),
    .FRAC_W(FRAC_W),
    .DEF_DIV_INT(DEF_DIV_INT)
  ) u_frac_div (
    .clk(clk),
    .rst(rst),
    .hold(!enable),
    .start(start),
    .div_int(active_d[DIV_W+FRAC_W-1:FRAC_W]),
    .div_frac(active_d[FRAC_W-1:0]),
    .tick_next(rx_next),
    .tick(rx_tick)
  );
  assign cfg_ready = !pend_q;
  assign cfg_err = err_q;
  assign tx_tick = tx_q;
  assign active_div = active_q;
endmodule

// File: tb/tb_uart_baud_tick_gen.sv
// tb_uart_baud_tick_gen: randomized self-checking bench against an arithmetic tick-schedule model
module tb_uart_baud_tick_gen;
  localparam int OS = 16;
  logic clk = 0, rst = 1, enable = 0, rx_resync = 0, cfg_valid = 0;
  logic [15:0] cfg_div_int = 0;
  logic [3:0] cfg_div_frac = 0;
  logic cfg_ready, cfg_err, rx_tick, tx_tick;
  logic [19:0] active_div;
  logic rx_prev = 0;
  int cyc = 0, tests = 0, fails = 0, tx_alone = 0, dbl = 0;
  int rx_t[$];
  bit tx_f[$];
  always #5 clk = ~clk;
  uart_baud_tick_gen dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .rx_resync(rx_resync),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_div_int(cfg_div_int),
    .cfg_div_frac(cfg_div_frac),
    .cfg_err(cfg_err),
    .rx_tick(rx_tick),
    .tx_tick(tx_tick),
    .active_div(active_div)
  );
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rx_tick === 1'b1) begin
      rx_t.push_back(cyc);
      tx_f.push_back(tx_tick === 1'b1);
    end
    if (tx_tick === 1'b1 && rx_tick !== 1'b1) tx_alone <= tx_alone + 1;
    if (rx_tick === 1'b1 && rx_prev) dbl <= dbl + 1;
    rx_prev <= rx_tick === 1'b1;
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  function automatic int tick_at(input int e0, input int n, input int f, input int k);
    int t = e0 + n;
    int acc = 0;
    for (int i = 0; i < k; i++) begin
      acc += f;
      t += n + acc / 16;
      acc %= 16;
    end
    return t;
  endfunction
  task automatic wait_ticks(input string tag, input int need, input int budget);
    for (int i = 0; i < budget && rx_t.size() < need; i++) step(1);
    chk({tag, "_count"}, rx_t.size() >= need, 1);
  endtask
  task automatic check_run(input string tag, input int e0, input int n, input int f, input int first, input int cnt);
    wait_ticks(tag, first + cnt, (n + 1) * (cnt + 2) + 20);
    for (int i = 0; i < cnt; i++) begin
      chk($sformatf("%s_rx%0d", tag, i), first + i < rx_t.size() ? rx_t[first + i] : -1, tick_at(e0, n, f, i));
      chk($sformatf("%s_tx%0d", tag, i), first + i < tx_f.size() ? tx_f[first + i] : 1'bx, (i + 1) % OS == 0);
    end
  endtask
  task automatic cfg_offer(input int di, input int df);
    cfg_valid = 1;
    cfg_div_int = 16'(di);
    cfg_div_frac = 4'(df);
    step(1);
    cfg_valid = 0;
  endtask
  task automatic restart();
    rx_t.delete();
    tx_f.delete();
    enable = 1;
  endtask
  initial begin
    int e0, n, f, t, r;
    step(3);
    chk("rst_rx", rx_tick, 0);
    chk("rst_tx", tx_tick, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_rdy", cfg_ready, 1);
    chk("rst_div", active_div, {16'd27, 4'd2});
    rst = 0;
    step(1);
    chk("idle_rx", rx_tick, 0);
    restart();
    e0 = cyc + 1;
    check_run("def", e0, 27, 2, 0, 32);
    enable = 0;
    step(1);
    rx_t.delete();
    tx_f.delete();
    step(40);
    chk("off_quiet", rx_t.size(), 0);
    cfg_offer(4, 8);
    chk("c48_rdy0", cfg_ready, 0);
    chk("c48_old", active_div, {16'd27, 4'd2});
    step(1);
    chk("c48_div", active_div, {16'd4, 4'd8});
    chk("c48_rdy1", cfg_ready, 1);
    restart();
    e0 = cyc + 1;
    check_run("c48", e0, 4, 8, 0, 32);
    for (int k = 0; k < 4; k++) begin
      enable = 0;
      step(1);
      n = k == 0 ? 2 : int'($urandom_range(2, 40));
      f = $urandom_range(0, 15);
      cfg_offer(n, f);
      step(1);
      chk($sformatf("rnd%0d_div", k), active_div, {16'(n), 4'(f)});
      restart();
      e0 = cyc + 1;
      check_run($sformatf("rnd%0d", k), e0, n, f, 0, 20);
    end
    enable = 0;
    step(1);
    cfg_offer($urandom_range(0, 1), $urandom_range(0, 15));
    chk("err_pulse", cfg_err, 1);
    chk("err_rdy", cfg_ready, 1);
    chk("err_div", active_div, {16'(n), 4'(f)});
    step(1);
    chk("err_once", cfg_err, 0);
    chk("err_div2", active_div, {16'(n), 4'(f)});
    cfg_offer(10, 0);
    step(1);
    restart();
    e0 = cyc + 1;
    step($urandom_range(5, 140));
    cfg_offer(5, 0);
    chk("mid_rdy0", cfg_ready, 0);
    chk("mid_keep", active_div, {16'd10, 4'd0});
    t = tick_at(e0, 10, 0, 15);
    while (cyc < t) step(1);
    chk("mid_tx", tx_tick, 1);
    chk("mid_rdy_tx", cfg_ready, 0);
    chk("mid_keep_tx", active_div, {16'd10, 4'd0});
    step(1);
    chk("mid_rdy1", cfg_ready, 1);
    chk("mid_div", active_div, {16'd5, 4'd0});
    check_run("mid_old", e0, 10, 0, 0, 16);
    check_run("mid_new", t + 1, 5, 0, 16, 20);
    enable = 0;
    step(1);
    n = $urandom_range(3, 20);
    f = $urandom_range(0, 15);
    cfg_offer(n, f);
    step(1);
    restart();
    e0 = cyc + 1;
    r = tick_at(e0, n, f, 15);
    while (cyc < r - 1) step(1);
    rx_resync = 1;
    step(1);
    rx_resync = 0;
    chk("rs_rx", rx_tick, 0);
    chk("rs_tx", tx_tick, 0);
    check_run("rs_pre", e0, n, f, 0, 15);
    check_run("rs_post", r, n, f, 15, 17);
    enable = 0;
    step(1);
    cfg_offer(6, 0);
    step(1);
    restart();
    wait_ticks("pre_rst", 7, 200);
    cfg_offer(9, 1);
    chk("prerst_rdy", cfg_ready, 0);
    rst = 1;
    step(1);
    chk("mrst_rx", rx_tick, 0);
    chk("mrst_tx", tx_tick, 0);
    chk("mrst_err", cfg_err, 0);
    chk("mrst_rdy", cfg_ready, 1);
    chk("mrst_div", active_div, {16'd27, 4'd2});
    rst = 0;
    r = cyc;
    rx_t.delete();
    tx_f.delete();
    check_run("post_rst", r + 1, 27, 2, 0, 20);
    chk("no_stray_tx", tx_alone, 0);
    chk("no_double", dbl, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
